qdi_arb_traffic_gen: RTL
========================

// Module: qdi_arb_traffic_gen
// PURPOSE
//  Synthesisable, clocked N-channel token source and checker for QDI arbiters.
//  Drives N_CH 1of1 request channels with LFSR-randomised, possibly simultaneous tokens.
//  Receives the arbiter's 1ofN_CH grant channel over a 4-phase handshake and counts tokens per rail.
//  Flags protocol and count errors. Sits between the clocked test harness and the arbiter under test.
// PARAMETERS
//  N_CH        2        number of request channels and grant rails (>=2)
//  NO_TOKENS   10       total tokens to issue, summed over all channels
//  CNT_W       16       width of every token counter
//  LFSR_SEED   16'hACE1 reset value of the 16-bit Fibonacci LFSR (taps 16,14,13,11); must be non-zero
//  SYNC_STAGES 2        flop stages on each asynchronous input (>=2)
//  TIMEOUT     4096     watchdog: cycles without handshake progress before an error is raised
// PORTS
//  CLK       in   1             clock
//  RESET     in   1             asynchronous, active-low reset
//  START     in   1             level; issuing runs while START=1
//  Tx        out  N_CH          1of1 request rails, one per channel
//  Txe       in   N_CH          per-channel enable from the arbiter (async); 0 = token consumed
//  Rx        in   N_CH          1ofN_CH grant rails from the arbiter (async)
//  Rxe       out  1             enable back to the arbiter; 1 = ready for a token
//  DONE      out  1             sticky; all tokens sent and received
//  ERR       out  1             sticky error flag
//  ERR_CODE  out  2             first error: 01 multi-rail, 10 over-receive, 11 timeout
//  TX_CNT    out  CNT_W         tokens issued
//  RX_CNT    out  CNT_W         tokens received
//  STATS     out  N_CH*CNT_W    per-rail receive counts; rail i is at [i*CNT_W +: CNT_W]
// BEHAVIOUR
//  Reset (RESET=0, asynchronous): Tx=0, Rxe=0, DONE=0, ERR=0, ERR_CODE=0, all counters 0,
//   LFSR=LFSR_SEED, all FSMs idle, synchroniser flops 0. Reset asserted mid-handshake aborts it immediately.
//  Rxe rises on the first clock edge after RESET is released.
//  Txe and Rx pass through SYNC_STAGES flops. All decisions use the synchronised values (Txe_s, Rx_s).
//  The LFSR advances every cycle while START=1 and DONE=0.
//  Tx FSM per channel i:
//   IDLE -> REQ when START & LFSR[i % 16] & Txe_s[i] & (TX_CNT + launches this cycle < NO_TOKENS).
//   REQ: Tx[i]=1. -> RTZ when Txe_s[i]=0.
//   RTZ: Tx[i]=0. -> IDLE when Txe_s[i]=1.
//   TX_CNT increments on IDLE->REQ.
//   Several channels may launch in the same cycle.
//   When fewer tokens remain than channels requesting, the lowest indices win.
//  Rx FSM:
//   WAIT (Rxe=1) -> ACK when exactly one Rx_s rail is 1.
//    On that transition: RX_CNT+1, STATS[rail]+1, Rxe=0 registered in the same cycle.
//   ACK (Rxe=0) -> WAIT when Rx_s is all 0; Rxe returns to 1.
//  Errors: only the first error is latched; ERR and ERR_CODE then hold until reset. Traffic continues.
//   01: two or more Rx_s rails are 1 in the same cycle.
//   10: RX_CNT would exceed TX_CNT.
//   11: TIMEOUT consecutive cycles with any FSM outside IDLE/WAIT and no state change.
//  DONE=1 when TX_CNT=RX_CNT=NO_TOKENS, all Tx FSMs are IDLE and the Rx FSM is in WAIT.
//   DONE is sticky; once set, no further launches.
//  Counters saturate at 2^CNT_W-1; they never wrap.
//  Latency: a token appears on Tx 1 cycle after launch. Rxe falls SYNC_STAGES+1 cycles after a rail rises.
// CONFIGURATION
//  ARB_TG_STATS_EN defined: the per-rail STATS counters are built.
//  ARB_TG_STATS_EN undefined: no per-rail counters; the STATS port is still present and tied to 0.
//   All other behaviour is identical.
// TESTING
//  1. Reset with START=0: Tx=00, Rxe=0 then 1 after RESET rises; counters 0; DONE=ERR=0.
//  2. N_CH=2, NO_TOKENS=10, ideal arbiter model (fixed delays): DONE=1, TX_CNT=RX_CNT=10,
//     STATS[0]+STATS[1]=10, ERR=0.
//  3. Force Rx=2'b11 for 5 cycles while in WAIT: ERR=1, ERR_CODE=01; TX_CNT unaffected.
//  4. Pulse Rx[0] with no token outstanding (TX_CNT=0): ERR=1, ERR_CODE=10; RX_CNT stays 0.
//  5. Hold Txe[1]=1 forever after Tx[1] rises, TIMEOUT=64: ERR_CODE=11 within 64+SYNC_STAGES+1 cycles.
//  6. Assert RESET mid-REQ: Tx drops asynchronously. Restart completes 10 tokens with ERR=0.

Source files
------------

// File: rtl/qdi_arb_traffic_gen.sv
// Clocked token source and grant checker for exercising QDI arbiters.
// Optional per-rail receive counters are built when ARB_TG_STATS_EN is defined.
module qdi_arb_traffic_gen #(
  parameter int          N_CH        = 2,
  parameter int          NO_TOKENS   = 10,
  parameter int          CNT_W       = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT     = 4096
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  output logic [N_CH-1:0]       Tx,
  input  logic [N_CH-1:0]       Txe,
  input  logic [N_CH-1:0]       Rx,
  output logic                  Rxe,
  output logic                  DONE,
  output logic                  ERR,
  output logic [1:0]            ERR_CODE,
  output logic [CNT_W-1:0]      TX_CNT,
  output logic [CNT_W-1:0]      RX_CNT,
  output logic [N_CH*CNT_W-1:0] STATS
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_REQ = 2'd1, TX_RTZ = 2'd2} tx_state_e;
  typedef enum logic {RX_WAIT = 1'b0, RX_ACK = 1'b1} rx_state_e;

  // All FSM state lives in one struct so checkers can bind to a single signal.
  typedef struct packed {
    tx_state_e [N_CH-1:0] tx;
    rx_state_e            rx;
  } fsm_state_t;

  fsm_state_t       r_state;
  fsm_state_t       w_state_next;
  logic [15:0]      r_lfsr;
  logic             r_rxe;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [WD_W-1:0]  r_wdog;

  logic [N_CH-1:0]  r_txe_sync [SYNC_STAGES];
  logic [N_CH-1:0]  r_rx_sync  [SYNC_STAGES];
  logic [N_CH-1:0]  w_txe_s;
  logic [N_CH-1:0]  w_rx_s;

  logic [N_CH-1:0]  w_launch;
  logic [31:0]      w_n_launch;
  logic [CNT_W:0]   w_tx_sum;
  logic             w_rx_any;
  logic             w_rx_multi;
  logic             w_rx_take;
  logic             w_over;
  logic             w_busy;
  logic             w_change;
  logic             w_timeout;
  logic             w_all_idle;
  logic             w_done_cond;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_txe_sync[s] <= '0;
        r_rx_sync[s]  <= '0;
      end
    end else begin
      r_txe_sync[0] <= Txe;
      r_rx_sync[0]  <= Rx;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_txe_sync[s] <= r_txe_sync[s-1];
        r_rx_sync[s]  <= r_rx_sync[s-1];
      end
    end
  end

  assign w_txe_s = r_txe_sync[SYNC_STAGES-1];
  assign w_rx_s  = r_rx_sync[SYNC_STAGES-1];

  // Launch arbitration walks channels upward, so the lowest indices win the last tokens.
  always_comb begin
    w_state_next = r_state;
    w_launch     = '0;
    w_n_launch   = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (r_state.tx[i])
        TX_IDLE: begin
          if (START && !r_done && r_lfsr[4'(i % 16)] && w_txe_s[i] &&
              (32'(r_tx_cnt) + w_n_launch < 32'(NO_TOKENS))) begin
            w_launch[i]        = 1'b1;
            w_state_next.tx[i] = TX_REQ;
            w_n_launch         = w_n_launch + 32'd1;
          end
        end
        TX_REQ:  if (!w_txe_s[i]) w_state_next.tx[i] = TX_RTZ;
        TX_RTZ:  if (w_txe_s[i])  w_state_next.tx[i] = TX_IDLE;
        default: w_state_next.tx[i] = TX_IDLE;
      endcase
    end

    w_rx_any   = |w_rx_s;
    w_rx_multi = (w_rx_s & (w_rx_s - 1'b1)) != '0;
    w_rx_take  = (r_state.rx == RX_WAIT) && w_rx_any && !w_rx_multi;
    w_over     = w_rx_take && (r_rx_cnt >= r_tx_cnt);
    case (r_state.rx)
      RX_WAIT: if (w_rx_take) w_state_next.rx = RX_ACK;
      RX_ACK:  if (!w_rx_any) w_state_next.rx = RX_WAIT;
      default: w_state_next.rx = RX_WAIT;
    endcase
  end

  always_comb begin
    w_all_idle = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (r_state.tx[i] != TX_IDLE) w_all_idle = 1'b0;
    end
    w_busy      = !w_all_idle || (r_state.rx != RX_WAIT);
    w_change    = (w_state_next != r_state);
    w_timeout   = w_busy && !w_change && (r_wdog == WD_W'(TIMEOUT - 1));
    w_tx_sum    = {1'b0, r_tx_cnt} + (CNT_W+1)'(w_n_launch);
    w_done_cond = (r_tx_cnt == CNT_W'(NO_TOKENS)) && (r_rx_cnt == CNT_W'(NO_TOKENS)) &&
                  w_all_idle && (r_state.rx == RX_WAIT);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= '0;
      r_lfsr     <= LFSR_SEED;
      r_rxe      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_tx_cnt   <= '0;
      r_rx_cnt   <= '0;
      r_wdog     <= '0;
    end else begin
      r_state <= w_state_next;
      r_rxe   <= (w_state_next.rx == RX_WAIT);
      r_done  <= r_done | w_done_cond;
      if (START && !r_done) begin
        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      end
      r_tx_cnt <= w_tx_sum[CNT_W] ? '1 : w_tx_sum[CNT_W-1:0];
      // An over-receive still completes the handshake but is not counted.
      if (w_rx_take && !w_over && (r_rx_cnt != '1)) begin
        r_rx_cnt <= r_rx_cnt + 1'b1;
      end
      if (!w_busy || w_change) begin
        r_wdog <= '0;
      end else if (r_wdog != WD_W'(TIMEOUT)) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (!r_err) begin
        if (w_rx_multi) begin
          r_err      <= 1'b1;
          r_err_code <= 2'b01;
        end else if (w_over) begin
          r_err      <= 1'b1;
          r_err_code <= 2'b10;
        end else if (w_timeout) begin
          r_err      <= 1'b1;
          r_err_code <= 2'b11;
        end
      end
    end
  end

`ifdef ARB_TG_STATS_EN
  localparam int RAIL_W = $clog2(N_CH);
  logic [CNT_W-1:0]  r_stats [N_CH];
  logic [RAIL_W-1:0] w_rail;

  always_comb begin
    w_rail = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_rx_s[i]) w_rail = RAIL_W'(i);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < N_CH; i++) r_stats[i] <= '0;
    end else if (w_rx_take && !w_over && (r_stats[w_rail] != '1)) begin
      r_stats[w_rail] <= r_stats[w_rail] + 1'b1;
    end
  end

  always_comb begin
    STATS = '0;
    for (int i = 0; i < N_CH; i++) STATS[i*CNT_W +: CNT_W] = r_stats[i];
  end
`else
  assign STATS = '0;
`endif

  always_comb begin
    Tx = '0;
    for (int i = 0; i < N_CH; i++) Tx[i] = (r_state.tx[i] == TX_REQ);
  end

  assign Rxe      = r_rxe;
  assign DONE     = r_done;
  assign ERR      = r_err;
  assign ERR_CODE = r_err_code;
  assign TX_CNT   = r_tx_cnt;
  assign RX_CNT   = r_rx_cnt;

endmodule
